// File: rtl/im_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package im_loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    WORD,
    DONE,
    ERR
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream input link plus instruction-memory write port and status outputs.
interface im_loader_if #(
  parameter int ADDR_WIDTH = 10
);

  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  im_we;
  logic [ADDR_WIDTH-1:0] im_addr;
  logic [31:0]           im_wdata;
  logic                  cpu_reset;
  logic                  done;
  logic                  err;

  // master: stream source and observer of the memory port; slave: the loader
  modport master (
    output byte_valid, byte_data,
    input  byte_ready, im_we, im_addr, im_wdata, cpu_reset, done, err
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, im_we, im_addr, im_wdata, cpu_reset, done, err
  );

endinterface

// File: rtl/im_loader_word_assembler.sv
// Collects four stream bytes, most significant first, into one 32-bit word.
module word_assembler
  import im_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        byte_stb_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  logic [BYTE_IDX_W-1:0] idx_q, idx_d;
  logic [23:0]           shift_q, shift_d;

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (byte_stb_i) begin
      idx_d   = idx_q + BYTE_IDX_W'(1);
      shift_d = {shift_q[15:0], byte_i};
    end
  end

  // The fourth byte completes the word combinationally so the top can register it on the same edge.
  assign word_valid_o = byte_stb_i && (idx_q == LAST_IDX);
  assign word_o       = {shift_q, byte_i};

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // Data bytes need no reset: a fresh word overwrites all three stored bytes.
  always_ff @(posedge clock) begin
    shift_q <= shift_d;
  end

endmodule

// File: rtl/im_loader.sv
// Boot loader: parses a counted big-endian word stream and writes it to instruction memory.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clock,
  input  logic        reset,
  im_loader_if.slave  bus
);

  localparam int          CNT_W    = ADDR_WIDTH + 1;
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

  state_e                state_q;
  logic [7:0]            nhi_q;
  logic [CNT_W-1:0]      nwords_q;
  logic [CNT_W-1:0]      widx_q, widx_d;
  logic [15:0]           hdr_d;
  logic                  xfer;
  logic                  word_valid;
  logic [31:0]           word;

  logic                  im_we_q;
  logic [ADDR_WIDTH-1:0] im_addr_q;
  logic [31:0]           im_wdata_q;
  logic                  cpu_reset_q;
  logic                  done_q;
  logic                  err_q;

  assign bus.byte_ready = !reset && (state_q inside {HDR_HI, HDR_LO, WORD});
  assign xfer           = bus.byte_valid && bus.byte_ready;
  assign hdr_d          = {nhi_q, bus.byte_data};
  assign widx_d         = widx_q + CNT_W'(1);

  word_assembler u_asm (
    .clock        (clock),
    .reset        (reset),
    .byte_stb_i   (xfer && (state_q == WORD)),
    .byte_i       (bus.byte_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= HDR_HI;
      widx_q      <= '0;
      im_we_q     <= 1'b0;
      im_addr_q   <= '0;
      im_wdata_q  <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      im_we_q <= 1'b0;
      case (state_q)
        HDR_HI: if (xfer) state_q <= HDR_LO;
        HDR_LO: begin
          if (xfer) begin
            // The 17-bit compare lets a count of exactly 2^ADDR_WIDTH through.
            if (hdr_d == 16'd0)                 state_q <= DONE;
            else if ({1'b0, hdr_d} > CAPACITY)  state_q <= ERR;
            else                                state_q <= WORD;
          end
        end
        WORD: begin
          if (word_valid) begin
            im_we_q    <= 1'b1;
            im_addr_q  <= widx_q[ADDR_WIDTH-1:0];
            im_wdata_q <= word;
            widx_q     <= widx_d;
            if (widx_d == nwords_q) state_q <= DONE;
          end
        end
        // Release the CPU one edge after DONE is entered, i.e. as the last strobe drops.
        DONE: begin
          done_q      <= 1'b1;
          cpu_reset_q <= 1'b0;
        end
        ERR:     err_q   <= 1'b1;
        default: state_q <= ERR;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (xfer && (state_q == HDR_HI)) nhi_q    <= bus.byte_data;
    if (xfer && (state_q == HDR_LO)) nwords_q <= CNT_W'(hdr_d);
  end

  assign bus.im_we     = im_we_q;
  assign bus.im_addr   = im_addr_q;
  assign bus.im_wdata  = im_wdata_q;
  assign bus.cpu_reset = cpu_reset_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: two instances (ADDR_WIDTH 10 and 4) against a stream-parsing model.
module tb_im_loader;

  typedef struct {
    int          sel;
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic        ready;
    logic        we;
    int          addr;
    logic [31:0] wdata;
    logic        cpu_reset;
    logic        done;
    logic        err;
  } obs_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst10, rst4;
  im_loader_if #(.ADDR_WIDTH(10)) if10 ();
  im_loader_if #(.ADDR_WIDTH(4))  if4 ();

  im_loader #(.ADDR_WIDTH(10)) u10 (.clock(clock), .reset(rst10), .bus(if10.slave));
  im_loader #(.ADDR_WIDTH(4))  u4  (.clock(clock), .reset(rst4),  .bus(if4.slave));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_offer_cyc = 0;
  bit mon_en = 1'b0;

  wr_t        wq[$];
  wr_t        exp_q[$];
  logic [7:0] stim[$];
  bit         exp_done, exp_err;
  int         done_cyc[2];
  bit         done_seen[2];
  int         inv_bad[2];

  always @(posedge clock) cyc <= cyc + 1;

  function automatic obs_t get_obs(input int sel);
    obs_t o;
    if (sel == 0) begin
      o.ready = if10.byte_ready; o.we = if10.im_we; o.addr = int'(if10.im_addr);
      o.wdata = if10.im_wdata; o.cpu_reset = if10.cpu_reset; o.done = if10.done; o.err = if10.err;
    end else begin
      o.ready = if4.byte_ready; o.we = if4.im_we; o.addr = int'(if4.im_addr);
      o.wdata = if4.im_wdata; o.cpu_reset = if4.cpu_reset; o.done = if4.done; o.err = if4.err;
    end
    return o;
  endfunction

  // Write capture and invariants: CPU stays in reset until done, never released while writing.
  always @(negedge clock) begin
    if (mon_en) begin
      for (int s = 0; s < 2; s++) begin
        obs_t o;
        wr_t w;
        o = get_obs(s);
        if (o.we === 1'b1) begin
          w.sel = s; w.addr = o.addr; w.data = o.wdata; w.cyc = cyc;
          wq.push_back(w);
          if (o.cpu_reset !== 1'b1) inv_bad[s]++;
        end
        if (o.done === 1'b1 && !done_seen[s]) begin
          done_seen[s] = 1'b1;
          done_cyc[s]  = cyc;
        end
        if (o.cpu_reset !== ~o.done) inv_bad[s]++;
      end
    end
  end

  task automatic set_in(input int sel, input logic r, input logic v, input logic [7:0] d);
    if (sel == 0) begin rst10 = r; if10.byte_valid = v; if10.byte_data = d; end
    else          begin rst4  = r; if4.byte_valid  = v; if4.byte_data  = d; end
  endtask

  task automatic offer(input int sel, input logic [7:0] b);
    set_in(sel, 1'b0, 1'b1, b);
    last_offer_cyc = cyc;
    @(posedge clock); #1;
    set_in(sel, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic idle(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      set_in(sel, 1'b0, 1'b0, 8'($urandom));
      @(posedge clock); #1;
    end
  endtask

  task automatic do_reset(input int sel, input logic v, input logic [7:0] d);
    obs_t o;
    set_in(sel, 1'b1, v, d);
    #1;
    o = get_obs(sel);
    checks++;
    if (o.ready !== 1'b0) begin
      errors++; $display("FAIL ready_in_reset sel=%0d got=%b want=0", sel, o.ready);
    end
    @(posedge clock); #1;
    o = get_obs(sel);
    checks++;
    if (o.we !== 1'b0 || o.addr !== 0 || o.wdata !== 32'h0 || o.cpu_reset !== 1'b1 ||
        o.done !== 1'b0 || o.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values sel=%0d got we=%b addr=%0d wdata=%h cpu_reset=%b done=%b err=%b want 0 0 0 1 0 0",
               sel, o.we, o.addr, o.wdata, o.cpu_reset, o.done, o.err);
    end
    set_in(sel, 1'b0, 1'b0, 8'h00);
    #1;
    o = get_obs(sel);
    checks++;
    if (o.ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset sel=%0d got=%b want=1", sel, o.ready);
    end
    done_seen[sel] = 1'b0;
    inv_bad[sel]   = 0;
  endtask

  // Reference: parse the offered stream as count + big-endian words, bounded by capacity.
  task automatic build_expect(input int sel, input int cap);
    int  n;
    wr_t w;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (stim.size() < 2) return;
    n = int'({stim[0], stim[1]});
    if (n == 0) exp_done = 1'b1;
    else if (n > cap) exp_err = 1'b1;
    else begin
      for (int i = 0; i < n; i++) begin
        if (2 + 4 * i + 3 < stim.size()) begin
          w.sel = sel; w.addr = i % cap; w.cyc = 0;
          w.data = {stim[2+4*i], stim[3+4*i], stim[4+4*i], stim[5+4*i]};
          exp_q.push_back(w);
        end
      end
      exp_done = (stim.size() >= 2 + 4 * n);
    end
  endtask

  task automatic run_stream(input int sel, input int gmin, input int gmax);
    foreach (stim[i]) begin
      idle(sel, int'($urandom_range(gmax, gmin)));
      offer(sel, stim[i]);
    end
    idle(sel, 3);
  endtask

  task automatic check_result(input int sel, input string name);
    obs_t o;
    wr_t  got[$];
    foreach (wq[i]) if (wq[i].sel == sel) got.push_back(wq[i]);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s write_count got=%0d want=%0d", name, got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i].addr !== exp_q[i].addr || got[i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL %s write[%0d] got addr=%0d data=%h want addr=%0d data=%h",
                 name, i, got[i].addr, got[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    o = get_obs(sel);
    checks++;
    if (o.done !== exp_done || o.err !== exp_err || o.cpu_reset !== !exp_done ||
        o.ready !== !(exp_done || exp_err)) begin
      errors++;
      $display("FAIL %s status got done=%b err=%b cpu_reset=%b ready=%b want %b %b %b %b", name,
               o.done, o.err, o.cpu_reset, o.ready, exp_done, exp_err, !exp_done, !(exp_done || exp_err));
    end
    checks++;
    if (inv_bad[sel] != 0) begin
      errors++;
      $display("FAIL %s cpu_reset_invariant violations got=%0d want=0", name, inv_bad[sel]);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    stim.push_back(w[31:24]); stim.push_back(w[23:16]);
    stim.push_back(w[15:8]);  stim.push_back(w[7:0]);
  endtask

  task automatic test_reset();
    do_reset(0, 1'b0, 8'h00);
    do_reset(1, 1'b0, 8'h00);
  endtask

  task automatic test_basic();
    do_reset(0, 1'b0, 8'h00);
    wq.delete();
    stim = '{8'h00, 8'h02};
    push_word(32'h20080005);
    push_word(32'h2109FFFF);
    build_expect(0, 1024);
    run_stream(0, 0, 0);
    check_result(0, "basic");
    checks++;
    if (wq.size() == 0 || !done_seen[0] || done_cyc[0] != wq[wq.size()-1].cyc + 1) begin
      errors++;
      $display("FAIL basic done_timing got done_cyc=%0d want last_strobe+1 (strobes=%0d)",
               done_cyc[0], wq.size());
    end
  endtask

  task automatic test_zero_count();
    do_reset(0, 1'b0, 8'h00);
    wq.delete();
    stim = '{8'h00, 8'h00};
    build_expect(0, 1024);
    run_stream(0, 0, 0);
    check_result(0, "zero_count");
    checks++;
    if (!done_seen[0] || done_cyc[0] != last_offer_cyc + 2) begin
      errors++;
      $display("FAIL zero_count done_timing got=%0d want=%0d", done_cyc[0], last_offer_cyc + 2);
    end
  endtask

  task automatic test_overflow();
    do_reset(1, 1'b0, 8'h00);
    wq.delete();
    stim = '{8'h00, 8'h11};
    for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
    build_expect(1, 16);
    run_stream(1, 0, 1);
    check_result(1, "overflow");
  endtask

  task automatic test_full_capacity();
    do_reset(1, 1'b0, 8'h00);
    wq.delete();
    stim = '{8'h00, 8'h10};
    for (int i = 0; i < 16; i++) push_word(32'(i) * 32'h01010101);
    build_expect(1, 16);
    run_stream(1, 0, 0);
    check_result(1, "full_capacity");
  endtask

  task automatic test_gaps();
    do_reset(0, 1'b0, 8'h00);
    wq.delete();
    stim = '{8'h00, 8'h02};
    push_word(32'h20080005);
    push_word(32'h2109FFFF);
    build_expect(0, 1024);
    run_stream(0, 2, 2);
    check_result(0, "gaps");
  endtask

  task automatic test_reset_midword();
    logic [31:0] w0;
    do_reset(0, 1'b0, 8'h00);
    wq.delete();
    w0 = $urandom;
    stim = '{8'h00, 8'h02};
    push_word(w0);
    stim.push_back(8'h11);
    stim.push_back(8'h22);
    run_stream(0, 0, 0);
    checks++;
    if (wq.size() != 1 || wq[0].addr != 0 || wq[0].data !== w0) begin
      errors++;
      $display("FAIL midword_pre_reset got count=%0d want 1 write addr=0 data=%h", wq.size(), w0);
    end
    // A byte offered during reset must be discarded (0xFF would otherwise read as an oversize header).
    do_reset(0, 1'b1, 8'hFF);
    wq.delete();
    stim = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    build_expect(0, 1024);
    run_stream(0, 0, 1);
    check_result(0, "midword_reset");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int sel, cap, n;
      sel = it % 2;
      cap = (sel == 0) ? 1024 : 16;
      n   = int'($urandom_range((sel == 0) ? 12 : 16, 1));
      do_reset(sel, 1'b0, 8'h00);
      wq.delete();
      stim = '{8'(n >> 8), 8'(n)};
      for (int i = 0; i < n; i++) push_word($urandom);
      for (int i = 0; i < 3; i++) stim.push_back(8'($urandom));
      build_expect(sel, cap);
      run_stream(sel, 0, 2);
      check_result(sel, $sformatf("random%0d", it));
    end
  endtask

  initial begin
    set_in(0, 1'b1, 1'b0, 8'h00);
    set_in(1, 1'b1, 1'b0, 8'h00);
    @(posedge clock); #1;
    @(posedge clock); #1;
    mon_en = 1'b1;
    test_reset();
    test_basic();
    test_zero_count();
    test_overflow();
    test_full_capacity();
    test_gaps();
    test_reset_midword();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
